// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/LS requester ports and the memory-side ports of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline/memory view.
interface mem_port_arbiter_if;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_ls_req;
    logic [31:0] i_ls_addr;
    logic [31:0] i_ls_wdata;
    logic [3:0]  i_ls_bmask;
    logic        i_ls_wren;
    logic        o_ls_gnt;
    logic        o_ls_rvalid;
    logic [31:0] o_ls_rdata;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr, i_ls_req, i_ls_addr, i_ls_wdata, i_ls_bmask, i_ls_wren,
        input  i_mem_rdata,
        output o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        output o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
    );

    modport master (
        output i_if_req, i_if_addr, i_ls_req, i_ls_addr, i_ls_wdata, i_ls_bmask, i_ls_wren,
        output i_mem_rdata,
        input  o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        input  o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port memory between instruction fetch and load/store.
// LS wins by default; a saturating starvation counter forces an IF grant after STARVE_LIMIT denials.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               i_clk,
    input logic               i_reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BMASK_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic force_if;
    logic if_gnt;
    logic ls_gnt;

    // Grant decision; held off entirely during reset so nothing reaches memory.
    always_comb begin
        force_if = 1'b0;
        if_gnt   = 1'b0;
        ls_gnt   = 1'b0;
        if (!i_reset) begin
            force_if = bus.i_if_req && (starve_cnt_q == LIMIT);
            if_gnt   = bus.i_if_req && (force_if || !bus.i_ls_req);
            ls_gnt   = bus.i_ls_req && !force_if;
        end
    end

    // Memory-side mux follows the grant; idle bus is all zeros.
    always_comb begin
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_mem_bmask = '0;
        bus.o_mem_wren  = 1'b0;
        if (ls_gnt) begin
            bus.o_mem_addr  = bus.i_ls_addr;
            bus.o_mem_wdata = bus.i_ls_wdata;
            bus.o_mem_bmask = BMASK_W'(bus.i_ls_bmask);
            bus.o_mem_wren  = bus.i_ls_wren;
        end else if (if_gnt) begin
            bus.o_mem_addr  = bus.i_if_addr;
        end
    end

    // Next state: starvation count and registered responses (store returns the pre-write word).
    always_comb begin
        starve_cnt_d = '0;
        if_rvalid_d  = if_gnt;
        ls_rvalid_d  = ls_gnt;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        if (bus.i_if_req && !if_gnt) begin
            starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + CNT_W'(1);
        end
        if (if_gnt) begin
            if_rdata_d = bus.i_mem_rdata;
        end
        if (ls_gnt) begin
            ls_rdata_d = bus.i_mem_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            starve_cnt_q <= '0;
            if_rvalid_q  <= 1'b0;
            ls_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            if_rvalid_q  <= if_rvalid_d;
            ls_rvalid_q  <= ls_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    assign bus.o_if_gnt    = if_gnt;
    assign bus.o_ls_gnt    = ls_gnt;
    assign bus.o_if_rvalid = if_rvalid_q;
    assign bus.o_ls_rvalid = ls_rvalid_q;
    assign bus.o_if_rdata  = if_rdata_q;
    assign bus.o_ls_rdata  = ls_rdata_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory (async word read, sync byte-masked write) between instruction fetch (IF) and load/store (LS).
- Grants at most one requester per cycle: LS has fixed priority, with a starvation counter that forces an IF grant after a bounded wait.
- Read data is registered and returned to the granted requester one cycle after grant.
- Sits between the pipeline front end / MEM stage and the memory block.

Parameters:
- STARVE_LIMIT, 4: consecutive denied IF-request cycles after which IF is granted over LS. Legal range 1..15. Counter width is 4 bits.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_if_req  in  1  IF requests a word read; held with address stable until granted
- i_if_addr  in  32  IF byte address
- o_if_gnt  out  1  IF request accepted this cycle (combinational)
- o_if_rvalid  out  1  o_if_rdata valid (registered, one cycle after grant)
- o_if_rdata  out  32  fetched word
- i_ls_req  in  1  LS requests an access; held stable until granted
- i_ls_addr  in  32  LS byte address
- i_ls_wdata  in  32  store data
- i_ls_bmask  in  4  store byte mask
- i_ls_wren  in  1  1 = store, 0 = load
- o_ls_gnt  out  1  LS request accepted this cycle (combinational)
- o_ls_rvalid  out  1  LS response valid, one cycle after grant; asserted for both loads and stores
- o_ls_rdata  out  32  load word; for a store, the pre-write word
- o_mem_addr  out  32  memory address
- o_mem_wdata  out  32  memory write data
- o_mem_bmask  out  4  memory byte mask
- o_mem_wren  out  1  memory write enable
- i_mem_rdata  in  32  memory async read data

Behaviour:
- Grant, combinational; evaluated only while i_reset=0:
  - force_if = i_if_req && (starve_cnt == STARVE_LIMIT)
  - o_if_gnt = i_if_req && (force_if || !i_ls_req)
  - o_ls_gnt = i_ls_req && !force_if
  - Grants are mutually exclusive, and a grant is never asserted without its request.
- Memory mux, combinational:
  - LS granted: o_mem_addr / wdata / bmask = LS inputs; o_mem_wren = i_ls_wren.
  - IF granted: o_mem_addr = i_if_addr; wdata = 0; bmask = 0; wren = 0.
  - No grant: all memory outputs 0.
- While i_reset=1: both grants = 0 and o_mem_wren = 0, regardless of requests. No write may reach memory during reset.
- Starvation counter (starve_cnt, 4 bits), at each edge with i_reset=0:
  - i_if_req && !o_if_gnt: increment, saturating at STARVE_LIMIT.
  - Otherwise (IF granted or not requesting): clear to 0.
- Response registers, at each edge with i_reset=0:
  - o_if_rvalid <= o_if_gnt; o_ls_rvalid <= o_ls_gnt.
  - If granted, the granted port's rdata <= i_mem_rdata. For a store this is the old word, since the read is async and the write lands on the same edge.
  - The non-granted port's rdata holds its value.
- Latency and throughput:
  - Grant in the request cycle; rvalid exactly 1 cycle later.
  - One transaction per cycle; back-to-back grants to the same port are allowed.
- Reset values: o_if_rvalid = 0, o_ls_rvalid = 0, o_if_rdata = 0, o_ls_rdata = 0, starve_cnt = 0.
- Reset mid-operation: a response due on the next edge is dropped (rvalid = 0 after reset). Requesters must re-issue.
- Requester rule: address and data held stable while req=1 and gnt=0. The arbiter stores no request state.
- A request deasserted before grant is simply abandoned. The counter clears if it was IF's.
- Address bits [1:0] are passed through unchanged; alignment is the requester's responsibility.

Test Plan:
- Reset: assert i_reset 2 cycles with both reqs high -> gnts 0, o_mem_wren 0, both rvalid/rdata 0. First cycle after release, with LS req high, LS is granted.
- IF only: i_if_req=1, addr=0x10, mem word[4]=0xDEADBEEF -> o_if_gnt=1 same cycle; next cycle o_if_rvalid=1, o_if_rdata=0xDEADBEEF. With req held, a grant every cycle.
- Conflict, LS priority:
  - Both req, LS store addr 0x20, wdata 0x12345678, bmask 4'b0011, old word 0xAABBCCDD.
  - Expect o_ls_gnt=1, o_if_gnt=0, o_mem_wren=1.
  - Next cycle: o_ls_rvalid=1, o_ls_rdata=0xAABBCCDD.
  - Memory word becomes 0xAABB5678.
- Starvation, STARVE_LIMIT=4: both req continuously -> LS granted cycles 0–3; IF granted cycle 4 with o_ls_gnt=0; LS granted cycles 5–8; IF granted cycle 9 (period 5).
- Reset mid-transaction: LS load granted, i_reset asserted on the following edge -> o_ls_rvalid stays 0 and starve_cnt = 0.
- Request withdrawal: IF denied 3 cycles, then i_if_req=0 for 1 cycle, then both req -> IF not forced until 4 further denied cycles.
